// File: rtl/shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_pipe
// Description : Pipelined Rijndael ShiftRows / InvShiftRows for states of NB
//               columns (NB = 4, 6 or 8). The direction is chosen per
//               transfer, so the encrypt and decrypt datapaths can share one
//               instance. The row permutation is pure wiring ahead of an
//               elastic valid/ready pipeline of STAGES registers.
//
// Parameters  : NB      - state columns (4, 6 or 8)
//               STAGES  - register stages (1..4), latency = STAGES cycles
//
// Ports       : clk        rising-edge clock
//               rst_n      synchronous active-low reset
//               in_valid   input transfer request
//               in_ready   block can accept this cycle
//               in_inv     0 = ShiftRows, 1 = InvShiftRows
//               in_state   input state, byte k = bits [8k+7:8k], k = 4*col+row
//               out_valid  output holds a result
//               out_ready  downstream accepts
//               out_inv    in_inv carried along with the result
//               out_state  permuted state
//               in_par     (SHIFT_ROWS_PAR_EN) even parity per input byte
//               out_perr   (SHIFT_ROWS_PAR_EN) parity mismatch of this result
//
// Options     : SHIFT_ROWS_PAR_EN - adds per-byte input parity checking.
//
// Revision    : 1.0 - initial release
// ============================================================================

module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [32*NB-1:0] in_state,
`ifdef SHIFT_ROWS_PAR_EN
    input  logic [4*NB-1:0]  in_par,
    output logic             out_perr,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_inv,
    output logic [32*NB-1:0] out_state
);

    localparam int W      = 32 * NB;
    localparam int NBYTES = 4 * NB;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("shift_rows_pipe: STAGES must be in 1..4");
        end
    endgenerate

    // Row r rotates by r columns, except for the 256-bit block where rows
    // 2 and 3 rotate one further (shifts 0,1,3,4).
    function automatic int row_shift(input int r);
        if (NB == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Permutation: both directions are fixed wiring, the mode only steers a
    // byte-wide mux. Source column indices are resolved at elaboration.
    // ------------------------------------------------------------------------
    logic [W-1:0] perm_fwd;
    logic [W-1:0] perm_inv;
    logic [W-1:0] perm;

    generate
        for (genvar c = 0; c < NB; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                localparam int DST     = 4 * c + r;
                localparam int SRC_FWD = 4 * ((c + row_shift(r)) % NB) + r;
                localparam int SRC_INV = 4 * ((c + NB - row_shift(r)) % NB) + r;
                assign perm_fwd[8*DST +: 8] = in_state[8*SRC_FWD +: 8];
                assign perm_inv[8*DST +: 8] = in_state[8*SRC_INV +: 8];
            end
        end
    endgenerate

    assign perm = in_inv ? perm_inv : perm_fwd;

`ifdef SHIFT_ROWS_PAR_EN
    // A byte is in error when its parity bit does not match the XOR of its
    // eight data bits; any erroneous byte flags the whole transfer.
    logic par_err;

    always_comb begin : p_parity
        par_err = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            par_err = par_err | ((^in_state[8*k +: 8]) ^ in_par[k]);
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Pipeline storage
    // ------------------------------------------------------------------------
    logic [STAGES-1:0]        v_q;
    logic [STAGES-1:0]        v_d;
    logic [STAGES-1:0]        inv_q;
    logic [STAGES-1:0]        inv_d;
    logic [STAGES-1:0][W-1:0] data_q;
    logic [STAGES-1:0][W-1:0] data_d;
`ifdef SHIFT_ROWS_PAR_EN
    logic [STAGES-1:0]        perr_q;
    logic [STAGES-1:0]        perr_d;
    logic [STAGES-1:0]        up_perr;
`endif

    // Values presented to each stage by its upstream neighbour
    logic [STAGES-1:0]        up_v;
    logic [STAGES-1:0]        up_inv;
    logic [STAGES-1:0][W-1:0] up_data;

    // Per-stage load enable
    logic [STAGES-1:0]        load;
    logic                     accept;

    // ------------------------------------------------------------------------
    // Backpressure chain: a stage loads when it is empty or when the stage
    // after it is about to take its contents. Evaluated from the output end
    // so that bubbles anywhere in the pipe are squeezed out in one cycle.
    // ------------------------------------------------------------------------
    always_comb begin : p_load
        logic rdy;
        rdy  = out_ready;
        load = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            load[i] = !v_q[i] || rdy;
            rdy     = load[i];
        end
    end

    // Held low during reset so no transfer is acknowledged that would then
    // be discarded.
    assign in_ready = rst_n && load[0];
    assign accept   = in_valid && in_ready;

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            if (i == 0) begin : g_first
                assign up_v[i]    = accept;
                assign up_inv[i]  = in_inv;
                assign up_data[i] = perm;
`ifdef SHIFT_ROWS_PAR_EN
                assign up_perr[i] = par_err;
`endif
            end else begin : g_next
                assign up_v[i]    = v_q[i-1];
                assign up_inv[i]  = inv_q[i-1];
                assign up_data[i] = data_q[i-1];
`ifdef SHIFT_ROWS_PAR_EN
                assign up_perr[i] = perr_q[i-1];
`endif
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state: an enabled stage always takes the upstream valid bit, but
    // only overwrites its payload when that upstream slot carries real data,
    // so an emptied stage keeps its last contents.
    // ------------------------------------------------------------------------
    always_comb begin : p_next
        v_d    = v_q;
        inv_d  = inv_q;
        data_d = data_q;
`ifdef SHIFT_ROWS_PAR_EN
        perr_d = perr_q;
`endif
        for (int i = 0; i < STAGES; i++) begin
            if (load[i]) begin
                v_d[i] = up_v[i];
                if (up_v[i]) begin
                    inv_d[i]  = up_inv[i];
                    data_d[i] = up_data[i];
`ifdef SHIFT_ROWS_PAR_EN
                    perr_d[i] = up_perr[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (!rst_n) begin
            v_q    <= '0;
            inv_q  <= '0;
            data_q <= '0;
`ifdef SHIFT_ROWS_PAR_EN
            perr_q <= '0;
`endif
        end else begin
            v_q    <= v_d;
            inv_q  <= inv_d;
            data_q <= data_d;
`ifdef SHIFT_ROWS_PAR_EN
            perr_q <= perr_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from the last stage
    // ------------------------------------------------------------------------
    assign out_valid = v_q[STAGES-1];
    assign out_inv   = inv_q[STAGES-1];
    assign out_state = data_q[STAGES-1];
`ifdef SHIFT_ROWS_PAR_EN
    assign out_perr  = perr_q[STAGES-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rows_pipe
// Description : Self-checking bench for shift_rows_pipe. Four instances cover
//               NB=4/STAGES=1, NB=4/STAGES=3, NB=8/STAGES=2, NB=6/STAGES=4.
//               Expected results come from a row/column reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   iv;
    logic [3:0]   ordy;
    logic [3:0]   ii;
    wire  [3:0]   ir;
    wire  [3:0]   ov;
    wire  [3:0]   oi;
    logic [255:0] ist [4];
    wire  [127:0] os0;
    wire  [127:0] os1;
    wire  [255:0] os2;
    wire  [191:0] os3;
`ifdef SHIFT_ROWS_PAR_EN
    logic [31:0]  ipar [4];
    wire  [3:0]   operr;
    logic [31:0]  par_flip;
    logic         perr_cap;
`endif

    int tests = 0;
    int fails = 0;

    shift_rows_pipe #(.NB(4), .STAGES(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_inv(ii[0]), .in_state(ist[0][127:0]),
`ifdef SHIFT_ROWS_PAR_EN
        .in_par(ipar[0][15:0]), .out_perr(operr[0]),
`endif
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_inv(oi[0]), .out_state(os0));

    shift_rows_pipe #(.NB(4), .STAGES(3)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_inv(ii[1]), .in_state(ist[1][127:0]),
`ifdef SHIFT_ROWS_PAR_EN
        .in_par(ipar[1][15:0]), .out_perr(operr[1]),
`endif
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_inv(oi[1]), .out_state(os1));

    shift_rows_pipe #(.NB(8), .STAGES(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_inv(ii[2]), .in_state(ist[2]),
`ifdef SHIFT_ROWS_PAR_EN
        .in_par(ipar[2]), .out_perr(operr[2]),
`endif
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_inv(oi[2]), .out_state(os2));

    shift_rows_pipe #(.NB(6), .STAGES(4)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_inv(ii[3]), .in_state(ist[3][191:0]),
`ifdef SHIFT_ROWS_PAR_EN
        .in_par(ipar[3][23:0]), .out_perr(operr[3]),
`endif
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_inv(oi[3]), .out_state(os3));

    // ------------------------------------------------------------------------
    // Helpers and reference model
    // ------------------------------------------------------------------------
    function automatic int nb_of(input int d);
        case (d)
            2:       return 8;
            3:       return 6;
            default: return 4;
        endcase
    endfunction

    function automatic int stages_of(input int d);
        case (d)
            1:       return 3;
            2:       return 2;
            3:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [255:0] dut_out(input int d);
        case (d)
            0:       return {128'b0, os0};
            1:       return {128'b0, os1};
            2:       return os2;
            default: return {64'b0, os3};
        endcase
    endfunction

    // out[r][c] = in[r][(c +/- shift(r)) mod nb]
    function automatic logic [255:0] ref_perm(input logic [255:0] s, input int nb, input bit inv);
        logic [255:0] o;
        int sh;
        int src;
        o = '0;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                sh  = (nb == 8 && r >= 2) ? r + 1 : r;
                src = inv ? (c - sh + nb) % nb : (c + sh) % nb;
                o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [255:0] rand_state(input int nb);
        logic [255:0] s;
        s = '0;
        for (int w = 0; w < nb; w++) begin
            s[32*w +: 32] = $urandom;
        end
        return s;
    endfunction

    function automatic logic [31:0] par_of(input logic [255:0] s);
        logic [31:0] p;
        for (int k = 0; k < 32; k++) begin
            p[k] = ^s[8*k +: 8];
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated transfer; returns the result and the number of edges
    // after the accepting edge before out_valid was seen.
    task automatic send_one(input int d, input logic [255:0] x, input bit inv,
                            output logic [255:0] y, output logic yi, output int lat);
        int k;
        @(negedge clk);
        iv[d]   = 1'b1;
        ist[d]  = x;
        ii[d]   = inv;
        ordy[d] = 1'b1;
`ifdef SHIFT_ROWS_PAR_EN
        ipar[d] = par_of(x) ^ par_flip;
`endif
        #1;
        k = 0;
        while (!ir[d] && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        lat   = 0;
        while (!ov[d] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("send_timeout", {255'b0, ov[d]}, 256'd1);
        y  = dut_out(d);
        yi = oi[d];
`ifdef SHIFT_ROWS_PAR_EN
        perr_cap = operr[d];
`endif
        @(negedge clk);
    endtask

    task automatic roundtrip(input int d, input logic [255:0] x, input string tag);
        logic [255:0] y;
        logic [255:0] z;
        logic         yi;
        int           lat;
        send_one(d, x, 1'b0, y, yi, lat);
        chk({tag, "_fwd"}, y, ref_perm(x, nb_of(d), 1'b0));
        send_one(d, y, 1'b1, z, yi, lat);
        chk({tag, "_inv_flag"}, {255'b0, yi}, 256'd1);
        chk({tag, "_identity"}, z, x);
        chk({tag, "_latency"}, lat, stages_of(d) - 1);
    endtask

    // Random stream with alternating direction; compares every output
    // against an in-order queue of model results.
    task automatic stream(input int d, input int n, input string tag);
        logic [255:0] qs [$];
        bit           qi [$];
        logic [255:0] prev_out;
        logic         prev_oi;
        bit           prev_stall;
        int           sent;
        int           cyc;
        int           nb;
        nb         = nb_of(d);
        sent       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        prev_oi    = 1'b0;
        while ((sent < n || qs.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            iv[d]   = (sent < n) && ($urandom_range(0, 3) != 0);
            ist[d]  = rand_state(nb);
            ii[d]   = sent[0];
            ordy[d] = $urandom_range(0, 1) == 1;
`ifdef SHIFT_ROWS_PAR_EN
            ipar[d] = par_of(ist[d]);
`endif
            #1;
            if (prev_stall) begin
                chk({tag, "_stall_state"}, dut_out(d), prev_out);
                chk({tag, "_stall_inv"}, {255'b0, oi[d]}, {255'b0, prev_oi});
            end
            if (ov[d] && ordy[d]) begin
                if (qs.size() == 0) begin
                    chk({tag, "_extra_output"}, {255'b0, ov[d]}, 256'd0);
                end else begin
                    chk({tag, "_state"}, dut_out(d), qs.pop_front());
                    chk({tag, "_inv"}, {255'b0, oi[d]}, {255'b0, qi.pop_front()});
                end
            end
            if (iv[d] && ir[d]) begin
                qs.push_back(ref_perm(ist[d], nb, ii[d]));
                qi.push_back(ii[d]);
                sent++;
            end
            prev_stall = ov[d] && !ordy[d];
            prev_out   = dut_out(d);
            prev_oi    = oi[d];
            cyc++;
        end
        @(negedge clk);
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        chk({tag, "_sent"}, sent, n);
        chk({tag, "_drained"}, qs.size(), 0);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [255:0] y;
        logic [255:0] x;
        logic [255:0] qexp [$];
        logic         yi;
        int           lat;
        int           acc;
        int           seen;

        rst_n = 1'b0;
        iv    = '0;
        ii    = '0;
        ordy  = '1;
        for (int d = 0; d < 4; d++) begin
            ist[d] = '0;
`ifdef SHIFT_ROWS_PAR_EN
            ipar[d] = '0;
`endif
        end
`ifdef SHIFT_ROWS_PAR_EN
        par_flip = '0;
        perr_cap = 1'b0;
`endif

        // Reset and post-reset state
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_during_reset", {252'b0, ir}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid", {252'b0, ov}, 256'd0);
        chk("reset_out_inv", {252'b0, oi}, 256'd0);
        chk("reset_in_ready", {252'b0, ir}, 256'hf);
        chk("reset_out_state0", dut_out(0), 256'd0);
        chk("reset_out_state2", dut_out(2), 256'd0);

        // Known-answer vectors, NB=4 STAGES=1
        x = 256'h0f0e0d0c0b0a09080706050403020100;
        send_one(0, x, 1'b0, y, yi, lat);
        chk("kat_fwd_state", y, 256'h0b06010c07020d08030e09040f0a0500);
        chk("kat_fwd_inv", {255'b0, yi}, 256'd0);
        chk("kat_fwd_latency", lat, 0);
        send_one(0, x, 1'b1, y, yi, lat);
        chk("kat_inv_state", y, 256'h0306090c0f0205080b0e0104070a0d00);
        chk("kat_inv_inv", {255'b0, yi}, 256'd1);

        // Round trips through every geometry
        for (int t = 0; t < 3; t++) begin
            roundtrip(0, rand_state(4), "rt_nb4_s1");
            roundtrip(1, rand_state(4), "rt_nb4_s3");
            roundtrip(2, rand_state(8), "rt_nb8_s2");
            roundtrip(3, rand_state(6), "rt_nb6_s4");
        end

        // NB=8 byte-index pattern
        for (int k = 0; k < 32; k++) begin
            x[8*k +: 8] = k[7:0];
        end
        send_one(2, x, 1'b0, y, yi, lat);
        chk("nb8_col1_bytes", {224'b0, y[63:32]}, 256'h17120904);
        chk("nb8_full", y, ref_perm(x, 8, 1'b0));
        chk("nb8_latency", lat, 1);

        // Long random streams with random backpressure
        stream(1, 1000, "stream_nb4_s3");
        stream(2, 200, "stream_nb8_s2");
        stream(3, 200, "stream_nb6_s4");
        stream(0, 100, "stream_nb4_s1");

        // Stall with STAGES=2: fills after two accepts, output holds
        acc = 0;
        x   = rand_state(8);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            iv[2]   = 1'b1;
            ist[2]  = x;
            ii[2]   = 1'b0;
            ordy[2] = 1'b0;
            #1;
            if (iv[2] && ir[2]) begin
                qexp.push_back(ref_perm(x, 8, 1'b0));
                acc++;
                x = rand_state(8);
            end
            if (c == 2) y = dut_out(2);
        end
        chk("stall_accepts", acc, 2);
        chk("stall_in_ready", {255'b0, ir[2]}, 256'd0);
        chk("stall_out_valid", {255'b0, ov[2]}, 256'd1);
        chk("stall_state_stable", dut_out(2), y);
        chk("stall_state_value", dut_out(2), qexp[0]);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            iv[2]   = 1'b1;
            ist[2]  = x;
            ordy[2] = 1'b1;
            #1;
            chk("release_in_ready", {255'b0, ir[2]}, 256'd1);
            chk("release_out_valid", {255'b0, ov[2]}, 256'd1);
            if (ov[2] && qexp.size() > 0) begin
                chk("release_state", dut_out(2), qexp.pop_front());
                seen++;
            end
            if (iv[2] && ir[2]) begin
                qexp.push_back(ref_perm(x, 8, 1'b0));
                x = rand_state(8);
            end
        end
        chk("release_outputs", seen, 6);
        @(negedge clk);
        iv[2] = 1'b0;
        repeat (4) @(negedge clk);

        // Reset with two transfers in flight in the 3-stage pipe
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            iv[1]   = 1'b1;
            ist[1]  = rand_state(4);
            ii[1]   = 1'b1;
            ordy[1] = 1'b1;
            #1;
            chk("flight_in_ready", {255'b0, ir[1]}, 256'd1);
        end
        @(negedge clk);
        iv[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", {255'b0, ir[1]}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midreset_out_valid", {255'b0, ov[1]}, 256'd0);
        chk("midreset_out_state", dut_out(1), 256'd0);
        chk("midreset_out_inv", {255'b0, oi[1]}, 256'd0);
        chk("midreset_in_ready_after", {255'b0, ir[1]}, 256'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (ov[1]) seen++;
        end
        chk("midreset_no_stale", seen, 0);

`ifdef SHIFT_ROWS_PAR_EN
        // Parity: only the transfer with a corrupted parity bit is flagged
        par_flip = '0;
        x = rand_state(4);
        send_one(0, x, 1'b0, y, yi, lat);
        chk("par_clean_before", {255'b0, perr_cap}, 256'd0);
        par_flip = 32'h0000_0200;
        send_one(0, x, 1'b0, y, yi, lat);
        chk("par_flagged", {255'b0, perr_cap}, 256'd1);
        chk("par_data_forwarded", y, ref_perm(x, 4, 1'b0));
        par_flip = '0;
        send_one(0, x, 1'b1, y, yi, lat);
        chk("par_clean_after", {255'b0, perr_cap}, 256'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
